cache_control_nway: RTL and testbench
=====================================

// Module: cache_control_nway
// PURPOSE
//  Control FSM for a WAYS-way set-associative, write-back, write-allocate cache.
//  Parametrised successor of the 2-way controller; sits between the CPU mem_* port and the pmem_* port.
//  Adds: N-way tree-PLRU, invalid-way-first victim choice, a registered victim, and saturating perf counters.
//  Tag, data, valid, dirty and PLRU arrays all live in the datapath; this block only drives their load/select lines.
// PARAMETERS
//  WAYS   4   number of ways; power of 2, >= 2
//  WAY_W  $clog2(WAYS)   victim index width (derived; do not override)
//  CNT_W  32  width of each perf counter
// PORTS
//  clk             in   1        clock; all state updates on posedge
//  reset           in   1        synchronous, active-high reset
//  mem_read        in   1        CPU read request; held until mem_resp
//  mem_write       in   1        CPU write request; held until mem_resp
//  mem_resp        out  1        request complete (single-cycle pulse)
//  hit_vec         in   WAYS     per-way tag match && valid, for the current index
//  valid_vec       in   WAYS     per-way valid bits, current index
//  dirty_vec       in   WAYS     per-way dirty bits, current index
//  plru_out        in   WAYS-1   PLRU tree bits read for the current index
//  plru_in         out  WAYS-1   updated PLRU tree bits
//  load_plru       out  1        write plru_in into the PLRU array
//  load_tag        out  WAYS     per-way tag array write enable
//  load_valid      out  WAYS     per-way valid array write enable (writes 1)
//  load_dirty      out  WAYS     per-way dirty array write enable
//  dirty_in        out  1        value written to the dirty array
//  load_data       out  WAYS     per-way data array write enable
//  datastore_in_sel out 1        data array source: 0 = pmem line, 1 = CPU write merge
//  pmem_addr_sel   out  1        pmem address: 0 = CPU tag/index, 1 = victim tag + index
//  victim_way      out  WAY_W    registered victim way
//  pmem_read       out  1        line read request to pmem
//  pmem_write      out  1        line write request to pmem
//  pmem_resp       in   1        pmem transfer done (single-cycle pulse)
//  hit_count       out  CNT_W    completed hits
//  miss_count      out  CNT_W    misses detected
//  wb_count        out  CNT_W    write-backs completed
// BEHAVIOUR
//  Reset values
//  - state = IDLE; victim_way = 0; all counters = 0.
//  - All outputs 0 in the reset cycle.
//  - Reset mid-WB/FILL aborts the transfer: pmem_read/pmem_write drop the next cycle.
//  - The datapath PLRU array is not cleared by this block.
//  Default outputs
//  - All load_*, pmem_*, mem_resp, dirty_in, datastore_in_sel and pmem_addr_sel = 0 unless stated below.
//  Request resolution
//  - req = mem_read | mem_write; mem_write wins if both are high (treated as a write).
//  - Hit way h = lowest set bit of hit_vec (multiple hits are tolerated, not expected).
//  Victim selection (combinational, IDLE only)
//  - If any valid_vec bit is 0: lowest-index invalid way.
//  - Otherwise: the PLRU tree walk.
//  - PLRU walk: node 0 is the root; node i has children 2i+1 and 2i+2.
//  - Bit = 0 -> victim is in the lower-index half; bit = 1 -> upper half.
//  PLRU update
//  - On access to way w, set every node on w's path to point away from w.
//  - Nodes off the path keep their plru_out value.
//  - WAYS=2: hit way0 -> plru_in = 1; hit way1 -> plru_in = 0.
//  FSM: IDLE
//  - req & hit: mem_resp=1, load_plru=1, plru_in=update(h), hit_count++.
//  - On a write hit, additionally: datastore_in_sel=1, load_data[h]=1, load_dirty[h]=1, dirty_in=1.
//  - req & miss: register victim v, miss_count++.
//    - Go to WB if valid_vec[v] & dirty_vec[v]; otherwise go to FILL.
//  - No req: stay in IDLE.
//  FSM: WB
//  - Outputs: pmem_write=1, pmem_addr_sel=1.
//  - Hold until pmem_resp; then wb_count++ and go to FILL.
//  FSM: FILL
//  - Every cycle: pmem_read=1, pmem_addr_sel=0, load_tag[v]=1, load_valid[v]=1, load_dirty[v]=1, dirty_in=0.
//  - load_data[v]=1 only in the pmem_resp cycle.
//  - On pmem_resp go to IDLE; the request then completes as a hit in the next cycle.
//  Latency
//  - Hit: mem_resp in the same cycle the request is presented.
//  - Clean miss: FILL cycles + 1.
//  - Dirty miss: WB cycles + FILL cycles + 1.
//  Counters
//  - Saturate at all-ones; never wrap.
//  - The hit cycle that follows a refill also counts as a hit.
// TESTING
//  1) WAYS=4, read to index 0 with all ways invalid
//     -> FILL into way0; victim_way=0; mem_resp 1 cycle after pmem_resp; miss=1, hit=1.
//  2) Fill ways 0..3 of one set, then read way0 again -> plru_in = 3'b011 (root=1, node1=1).
//     A fifth tag then evicts way2.
//  3) Write hit on way1
//     -> same-cycle mem_resp; load_data=4'b0010, load_dirty=4'b0010, dirty_in=1, datastore_in_sel=1.
//  4) Miss whose victim is valid and dirty
//     -> WB with pmem_write=1, pmem_addr_sel=1 until pmem_resp; then FILL; wb_count=1.
//  5) Assert reset during FILL with pmem_resp never returned
//     -> state=IDLE, pmem_read=0 next cycle, all counters 0.
//  6) CNT_W=2: complete 5 hits -> hit_count saturates at 3.
//     WAYS=2 case: hit way0 -> plru_in=1; hit way1 -> plru_in=0.

Source files
------------

// File: rtl/cache_control_nway.sv
// ============================================================================
// Module      : cache_control_nway
// Description : Control FSM for a WAYS-way set-associative write-back,
//               write-allocate cache with tree-PLRU and saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cache_control_nway #(
  parameter int WAYS  = 4,
  parameter int WAY_W = $clog2(WAYS),
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              mem_resp,
  input  logic [WAYS-1:0]   hit_vec,
  input  logic [WAYS-1:0]   valid_vec,
  input  logic [WAYS-1:0]   dirty_vec,
  input  logic [WAYS-2:0]   plru_out,
  output logic [WAYS-2:0]   plru_in,
  output logic              load_plru,
  output logic [WAYS-1:0]   load_tag,
  output logic [WAYS-1:0]   load_valid,
  output logic [WAYS-1:0]   load_dirty,
  output logic              dirty_in,
  output logic [WAYS-1:0]   load_data,
  output logic              datastore_in_sel,
  output logic              pmem_addr_sel,
  output logic [WAY_W-1:0]  victim_way,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  wb_count
);

  typedef enum logic [1:0] {
    c_idle = 2'd0,
    c_wb   = 2'd1,
    c_fill = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t             r_state;
  logic [WAY_W-1:0]   r_victim;
  logic [CNT_W-1:0]   r_hit_cnt;
  logic [CNT_W-1:0]   r_miss_cnt;
  logic [CNT_W-1:0]   r_wb_cnt;

  logic               w_req;
  logic               w_hit;
  logic [WAY_W-1:0]   w_hit_way;
  logic [WAY_W-1:0]   w_victim;
  logic [WAYS-1:0]    w_hit_oh;
  logic [WAYS-1:0]    w_vic_oh;

  function automatic logic [WAY_W-1:0] lowest_set(input logic [WAYS-1:0] v);
    lowest_set = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = WAY_W'(i);
    end
  endfunction

  // Tree is padded to WAYS bits so a WAY_W-bit node index always fits.
  function automatic logic [WAY_W-1:0] plru_walk(input logic [WAYS-2:0] t);
    logic [WAYS-1:0]  tree;
    logic [WAY_W-1:0] node;
    logic             b;
    tree      = {1'b0, t};
    node      = '0;
    plru_walk = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b         = tree[node];
      plru_walk = WAY_W'({plru_walk, b});
      node      = WAY_W'(2 * int'(node) + 1 + int'(b));
    end
  endfunction

  function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] t,
                                                  input logic [WAY_W-1:0] w);
    logic [WAYS-1:0]  tree;
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] path;
    logic             b;
    tree = {1'b0, t};
    node = '0;
    path = w;
    for (int l = 0; l < WAY_W; l++) begin
      b          = path[WAY_W-1];
      tree[node] = ~b;
      node       = WAY_W'(2 * int'(node) + 1 + int'(b));
      path       = path << 1;
    end
    plru_update = tree[WAYS-2:0];
  endfunction

  assign w_req     = mem_read | mem_write;
  assign w_hit     = |hit_vec;
  assign w_hit_way = lowest_set(hit_vec);
  assign w_victim  = (&valid_vec) ? plru_walk(plru_out) : lowest_set(~valid_vec);
  assign w_hit_oh  = WAYS'(1) << w_hit_way;
  assign w_vic_oh  = WAYS'(1) << r_victim;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_idle;
      r_victim   <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_req && w_hit) begin
            if (r_hit_cnt != c_cnt_max) r_hit_cnt <= r_hit_cnt + c_cnt_one;
          end else if (w_req) begin
            r_victim <= w_victim;
            if (r_miss_cnt != c_cnt_max) r_miss_cnt <= r_miss_cnt + c_cnt_one;
            r_state <= (valid_vec[w_victim] && dirty_vec[w_victim]) ? c_wb : c_fill;
          end
        end
        c_wb: begin
          if (pmem_resp) begin
            if (r_wb_cnt != c_cnt_max) r_wb_cnt <= r_wb_cnt + c_cnt_one;
            r_state <= c_fill;
          end
        end
        c_fill: begin
          if (pmem_resp) r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  // Outputs are forced low throughout any reset cycle, whatever the state.
  always_comb begin
    mem_resp         = 1'b0;
    plru_in          = '0;
    load_plru        = 1'b0;
    load_tag         = '0;
    load_valid       = '0;
    load_dirty       = '0;
    dirty_in         = 1'b0;
    load_data        = '0;
    datastore_in_sel = 1'b0;
    pmem_addr_sel    = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    if (!reset) begin
      case (r_state)
        c_idle: begin
          if (w_req && w_hit) begin
            mem_resp  = 1'b1;
            load_plru = 1'b1;
            plru_in   = plru_update(plru_out, w_hit_way);
            if (mem_write) begin
              datastore_in_sel = 1'b1;
              load_data        = w_hit_oh;
              load_dirty       = w_hit_oh;
              dirty_in         = 1'b1;
            end
          end
        end
        c_wb: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
        end
        c_fill: begin
          pmem_read  = 1'b1;
          load_tag   = w_vic_oh;
          load_valid = w_vic_oh;
          load_dirty = w_vic_oh;
          if (pmem_resp) load_data = w_vic_oh;
        end
        default: ;
      endcase
    end
  end

  assign victim_way = reset ? '0 : r_victim;
  assign hit_count  = reset ? '0 : r_hit_cnt;
  assign miss_count = reset ? '0 : r_miss_cnt;
  assign wb_count   = reset ? '0 : r_wb_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cache_control_nway.sv
// ============================================================================
// Module      : tb_cache_control_nway
// Description : Directed scoreboard bench for cache_control_nway (4-way and
//               2-way/2-bit-counter instances).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cache_control_nway;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-way instance
  logic        mem_read, mem_write, mem_resp;
  logic [3:0]  hit_vec, valid_vec, dirty_vec;
  logic [2:0]  plru_out, plru_in;
  logic        load_plru, dirty_in, datastore_in_sel, pmem_addr_sel;
  logic [3:0]  load_tag, load_valid, load_dirty, load_data;
  logic [1:0]  victim_way;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [31:0] hit_count, miss_count, wb_count;

  // 2-way instance with 2-bit counters
  logic        mem_read2, mem_write2, mem_resp2;
  logic [1:0]  hit_vec2, valid_vec2, dirty_vec2;
  logic [0:0]  plru_out2, plru_in2;
  logic        load_plru2, dirty_in2, datastore_in_sel2, pmem_addr_sel2;
  logic [1:0]  load_tag2, load_valid2, load_dirty2, load_data2;
  logic [0:0]  victim_way2;
  logic        pmem_read2, pmem_write2, pmem_resp2;
  logic [1:0]  hit_count2, miss_count2, wb_count2;

  cache_control_nway #(.WAYS(4), .CNT_W(32)) u_dut4 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .hit_vec(hit_vec), .valid_vec(valid_vec),
    .dirty_vec(dirty_vec), .plru_out(plru_out), .plru_in(plru_in),
    .load_plru(load_plru), .load_tag(load_tag), .load_valid(load_valid),
    .load_dirty(load_dirty), .dirty_in(dirty_in), .load_data(load_data),
    .datastore_in_sel(datastore_in_sel), .pmem_addr_sel(pmem_addr_sel),
    .victim_way(victim_way), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .hit_count(hit_count), .miss_count(miss_count),
    .wb_count(wb_count)
  );

  cache_control_nway #(.WAYS(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .mem_read(mem_read2), .mem_write(mem_write2),
    .mem_resp(mem_resp2), .hit_vec(hit_vec2), .valid_vec(valid_vec2),
    .dirty_vec(dirty_vec2), .plru_out(plru_out2), .plru_in(plru_in2),
    .load_plru(load_plru2), .load_tag(load_tag2), .load_valid(load_valid2),
    .load_dirty(load_dirty2), .dirty_in(dirty_in2), .load_data(load_data2),
    .datastore_in_sel(datastore_in_sel2), .pmem_addr_sel(pmem_addr_sel2),
    .victim_way(victim_way2), .pmem_read(pmem_read2), .pmem_write(pmem_write2),
    .pmem_resp(pmem_resp2), .hit_count(hit_count2), .miss_count(miss_count2),
    .wb_count(wb_count2)
  );

  typedef struct {
    string       tag;
    logic [95:0] exp;
    logic [95:0] mask;
  } sb_t;

  sb_t         sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] eh = 0, em = 0, ew = 0;
  logic [1:0]  eh2 = 0;

  // Layout: resp, plru_in[2:0], load_plru, tag, valid, dirty, dirty_in,
  //         data, ds_sel, addr_sel, victim[1:0], pmem_read, pmem_write
  function automatic logic [27:0] pack_ctl(input logic resp, input logic [2:0] pin,
      input logic lp, input logic [3:0] lt, input logic [3:0] lv, input logic [3:0] ld,
      input logic din, input logic [3:0] ldat, input logic ds, input logic as,
      input logic [1:0] vw, input logic pr, input logic pw);
    return {resp, pin, lp, lt, lv, ld, din, ldat, ds, as, vw, pr, pw};
  endfunction

  function automatic logic [3:0] oh(input logic [1:0] w);
    logic [3:0] one;
    one = 4'b0001;
    return one << w;
  endfunction

  function automatic logic [27:0] e_idle(input logic [1:0] vw);
    return pack_ctl(0, 3'b0, 0, 4'b0, 4'b0, 4'b0, 0, 4'b0, 0, 0, vw, 0, 0);
  endfunction

  function automatic logic [27:0] e_hit(input logic [1:0] h, input logic [2:0] pin,
                                        input logic [1:0] vw, input logic wr);
    return pack_ctl(1, pin, 1, 4'b0, 4'b0, wr ? oh(h) : 4'b0, wr,
                    wr ? oh(h) : 4'b0, wr, 0, vw, 0, 0);
  endfunction

  function automatic logic [27:0] e_fill(input logic [1:0] v, input logic resp);
    return pack_ctl(0, 3'b0, 0, oh(v), oh(v), oh(v), 0, resp ? oh(v) : 4'b0,
                    0, 0, v, 1, 0);
  endfunction

  function automatic logic [27:0] e_wb(input logic [1:0] v);
    return pack_ctl(0, 3'b0, 0, 4'b0, 4'b0, 4'b0, 0, 4'b0, 0, 1, v, 0, 1);
  endfunction

  task automatic cmp(input logic [95:0] obs);
    sb_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e = sb.pop_front();
    assert ((obs & e.mask) === (e.exp & e.mask)) else begin
      n_bad++;
      $error("FAIL %s: got %h, required %h", e.tag, obs & e.mask, e.exp & e.mask);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic rd, input logic wr,
                      input logic [3:0] hv, input logic [3:0] vv, input logic [3:0] dv,
                      input logic [2:0] po, input logic pr, input logic [27:0] exp,
                      input logic ih, input logic im, input logic iw);
    logic [95:0] m;
    reset = rst; mem_read = rd; mem_write = wr; hit_vec = hv;
    valid_vec = vv; dirty_vec = dv; plru_out = po; pmem_resp = pr;
    // plru_in only matters when it is being loaded
    m = exp[23] ? '1 : ~(96'h7 << 24);
    sb.push_back('{tag, {68'b0, exp}, m});
    sb.push_back('{{tag, "_cnt"}, rst ? 96'b0 : {eh, em, ew}, '1});
    @(negedge clk);
    cmp({68'b0, mem_resp, plru_in, load_plru, load_tag, load_valid, load_dirty,
         dirty_in, load_data, datastore_in_sel, pmem_addr_sel, victim_way,
         pmem_read, pmem_write});
    cmp({hit_count, miss_count, wb_count});
    @(posedge clk); #1;
    if (rst) begin
      eh = 0; em = 0; ew = 0; eh2 = 0;
    end else begin
      eh = eh + 32'(ih); em = em + 32'(im); ew = ew + 32'(iw);
    end
  endtask

  task automatic step2(input string tag, input logic rd, input logic [1:0] hv,
                       input logic po, input logic resp, input logic pin, input logic ih);
    mem_read2 = rd; hit_vec2 = hv; plru_out2 = po;
    sb.push_back('{tag, {93'b0, resp, resp, pin}, resp ? 96'h7 : 96'h6});
    sb.push_back('{{tag, "_cnt"}, {94'b0, eh2}, '1});
    @(negedge clk);
    cmp({93'b0, mem_resp2, load_plru2, plru_in2});
    cmp({94'b0, hit_count2});
    @(posedge clk); #1;
    if (ih && eh2 != 2'b11) eh2 = eh2 + 2'b01;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; mem_read = 0; mem_write = 0; hit_vec = 0; valid_vec = 0;
    dirty_vec = 0; plru_out = 0; pmem_resp = 0;
    mem_read2 = 0; mem_write2 = 0; hit_vec2 = 0; valid_vec2 = 2'b11;
    dirty_vec2 = 0; plru_out2 = 0; pmem_resp2 = 0;
    @(posedge clk); #1;

    step("rst_outputs", 1, 1, 0, 4'b0001, 4'b0001, 4'b0, 3'b000, 1, e_idle(0), 0, 0, 0);

    // Read miss into an empty set
    step("t1_miss",      0, 1, 0, 4'b0000, 4'b0000, 4'b0, 3'b000, 0, e_idle(0),    0, 1, 0);
    step("t1_fill",      0, 1, 0, 4'b0000, 4'b0000, 4'b0, 3'b000, 0, e_fill(0, 0), 0, 0, 0);
    step("t1_fill_resp", 0, 1, 0, 4'b0000, 4'b0000, 4'b0, 3'b000, 1, e_fill(0, 1), 0, 0, 0);
    step("t1_hit",       0, 1, 0, 4'b0001, 4'b0001, 4'b0, 3'b000, 0, e_hit(0, 3'b011, 0, 0), 1, 0, 0);
    step("t1_idle",      0, 0, 0, 4'b0001, 4'b0001, 4'b0, 3'b011, 0, e_idle(0),    0, 0, 0);

    // Fill remaining ways, walking the PLRU state
    step("t2_miss1", 0, 1, 0, 4'b0000, 4'b0001, 4'b0, 3'b011, 0, e_idle(0),    0, 1, 0);
    step("t2_fill1", 0, 1, 0, 4'b0000, 4'b0001, 4'b0, 3'b011, 1, e_fill(1, 1), 0, 0, 0);
    step("t2_hit1",  0, 1, 0, 4'b0010, 4'b0011, 4'b0, 3'b011, 0, e_hit(1, 3'b001, 1, 0), 1, 0, 0);
    step("t2_miss2", 0, 1, 0, 4'b0000, 4'b0011, 4'b0, 3'b001, 0, e_idle(1),    0, 1, 0);
    step("t2_fill2", 0, 1, 0, 4'b0000, 4'b0011, 4'b0, 3'b001, 1, e_fill(2, 1), 0, 0, 0);
    step("t2_hit2",  0, 1, 0, 4'b0100, 4'b0111, 4'b0, 3'b001, 0, e_hit(2, 3'b100, 2, 0), 1, 0, 0);
    step("t2_miss3", 0, 1, 0, 4'b0000, 4'b0111, 4'b0, 3'b100, 0, e_idle(2),    0, 1, 0);
    step("t2_fill3", 0, 1, 0, 4'b0000, 4'b0111, 4'b0, 3'b100, 1, e_fill(3, 1), 0, 0, 0);
    step("t2_hit3",  0, 1, 0, 4'b1000, 4'b1111, 4'b0, 3'b100, 0, e_hit(3, 3'b000, 3, 0), 1, 0, 0);
    step("t2_reread0", 0, 1, 0, 4'b0001, 4'b1111, 4'b0, 3'b000, 0, e_hit(0, 3'b011, 3, 0), 1, 0, 0);
    step("t2_evict_miss", 0, 1, 0, 4'b0000, 4'b1111, 4'b0, 3'b011, 0, e_idle(3),  0, 1, 0);
    step("t2_evict_fill", 0, 1, 0, 4'b0000, 4'b1111, 4'b0, 3'b011, 1, e_fill(2, 1), 0, 0, 0);
    step("t2_evict_hit",  0, 1, 0, 4'b0100, 4'b1111, 4'b0, 3'b011, 0, e_hit(2, 3'b110, 2, 0), 1, 0, 0);

    // Write hit on way1
    step("t3_write_hit", 0, 0, 1, 4'b0010, 4'b1111, 4'b0, 3'b110, 0, e_hit(1, 3'b101, 2, 1), 1, 0, 0);

    // Dirty victim (read+write both high acts as a write)
    step("t4_miss",    0, 1, 1, 4'b0000, 4'b1111, 4'b1000, 3'b101, 0, e_idle(2),    0, 1, 0);
    step("t4_wb",      0, 1, 1, 4'b0000, 4'b1111, 4'b1000, 3'b101, 0, e_wb(3),      0, 0, 0);
    step("t4_wb_resp", 0, 1, 1, 4'b0000, 4'b1111, 4'b1000, 3'b101, 1, e_wb(3),      0, 0, 1);
    step("t4_fill",    0, 1, 1, 4'b0000, 4'b1111, 4'b0000, 3'b101, 1, e_fill(3, 1), 0, 0, 0);
    step("t4_hit",     0, 1, 1, 4'b1000, 4'b1111, 4'b0000, 3'b101, 0, e_hit(3, 3'b000, 3, 1), 1, 0, 0);
    step("t4_idle",    0, 0, 0, 4'b1000, 4'b1111, 4'b1000, 3'b000, 0, e_idle(3),    0, 0, 0);

    // Reset while a fill is outstanding
    step("t5_miss",   0, 1, 0, 4'b0000, 4'b0111, 4'b0, 3'b000, 0, e_idle(3),    0, 1, 0);
    step("t5_fill",   0, 1, 0, 4'b0000, 4'b0111, 4'b0, 3'b000, 0, e_fill(3, 0), 0, 0, 0);
    step("t5_reset",  1, 1, 0, 4'b0000, 4'b0111, 4'b0, 3'b000, 0, e_idle(0),    0, 0, 0);
    step("t5_after",  0, 0, 0, 4'b0000, 4'b0111, 4'b0, 3'b000, 0, e_idle(0),    0, 0, 0);

    // 2-way PLRU and counter saturation
    step2("t6_hit_a", 1, 2'b01, 1'b0, 1, 1'b1, 1);
    step2("t6_hit_b", 1, 2'b10, 1'b1, 1, 1'b0, 1);
    step2("t6_hit_c", 1, 2'b01, 1'b0, 1, 1'b1, 1);
    step2("t6_hit_d", 1, 2'b10, 1'b1, 1, 1'b0, 1);
    step2("t6_hit_e", 1, 2'b01, 1'b0, 1, 1'b1, 1);
    step2("t6_sat",   0, 2'b00, 1'b0, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
